// File: rtl/gated_sr_pkg.sv
// Shared definitions for the gated SR bank.
// Holds the S=R=1 resolution mode encodings and the next-state function
// used by every storage cell.
package gated_sr_pkg;

    localparam int unsigned MODE_HOLD    = 0;
    localparam int unsigned MODE_SET_DOM = 1;
    localparam int unsigned MODE_RST_DOM = 2;
    localparam int unsigned MODE_TOGGLE  = 3;

    // Next q for one enabled cell given the current set/reset pair.
    function automatic logic sr_next_q(input int unsigned mode,
                                       input logic s,
                                       input logic r,
                                       input logic q);
        logic nq;
        nq = q;
        case ({s, r})
            2'b10:   nq = 1'b1;
            2'b01:   nq = 1'b0;
            2'b11: begin
                case (mode)
                    MODE_SET_DOM: nq = 1'b1;
                    MODE_RST_DOM: nq = 1'b0;
                    MODE_TOGGLE:  nq = ~q;
                    default:      nq = q;
                endcase
            end
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/gated_sr_bank_if.sv
// Bus bundle for the gated SR bank.
// Control side: en, ch_en, s, r, clr, err_clr.
// Status side:  q, q_n, invalid, invalid_any, inv_cnt.
// master = the agent driving the controls, slave = the bank itself.
interface gated_sr_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic [WIDTH-1:0] ch_en;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             clr;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] invalid;
    logic             invalid_any;
    logic [CNT_W-1:0] inv_cnt;

    modport master (
        output en, ch_en, s, r, clr, err_clr,
        input  q, q_n, invalid, invalid_any, inv_cnt
    );

    modport slave (
        input  en, ch_en, s, r, clr, err_clr,
        output q, q_n, invalid, invalid_any, inv_cnt
    );
endinterface

// File: rtl/gated_sr_bank_sr_cell.sv
// One clocked SR storage channel with its sticky invalid flag.
// Ports:
//   clk, rst_n  - rising-edge clock, async active-low reset
//   en_i        - combined enable (global & per-channel)
//   s, r        - set / reset request
//   clr         - synchronous load of reset_val into q
//   err_clr     - synchronous clear of the invalid flag
//   reset_val   - value q takes on reset and on clr
//   q           - stored state
//   inv_evt     - this cycle carries an enabled S=R=1 (feeds the bank counter)
//   invalid     - sticky record of any past inv_evt
module sr_cell
    import gated_sr_pkg::*;
#(
    parameter int unsigned MODE = MODE_HOLD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic s,
    input  logic r,
    input  logic clr,
    input  logic err_clr,
    input  logic reset_val,
    output logic q,
    output logic inv_evt,
    output logic invalid
);

    assign inv_evt = en_i & s & r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= reset_val;
        end else if (clr) begin
            q <= reset_val;
        end else if (en_i) begin
            q <= sr_next_q(MODE, s, r, q);
        end
    end

    // A fresh event outranks err_clr so no event is lost on the clear cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            invalid <= 1'b0;
        end else if (inv_evt) begin
            invalid <= 1'b1;
        end else if (err_clr) begin
            invalid <= 1'b0;
        end
    end

endmodule

// File: rtl/gated_sr_bank.sv
// Bank of WIDTH clocked SR cells with shared global enable, per-channel
// enables, sticky invalid flags and a saturating invalid-event counter.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - gated_sr_bank_if slave: controls in, q/q_n/invalid/
//            invalid_any/inv_cnt out
module gated_sr_bank
    import gated_sr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int unsigned      MODE      = MODE_HOLD,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gated_sr_bank_if.slave       bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (MODE > MODE_TOGGLE) begin : g_bad_mode
        $error("gated_sr_bank: MODE must be 0..3");
    end

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] inv_evt;
    logic [WIDTH-1:0] invalid;
    logic             any_evt;
    logic             invalid_any;
    logic [CNT_W-1:0] inv_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(.MODE(MODE)) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (bus.en & bus.ch_en[i]),
            .s         (bus.s[i]),
            .r         (bus.r[i]),
            .clr       (bus.clr),
            .err_clr   (bus.err_clr),
            .reset_val (RESET_VAL[i]),
            .q         (q[i]),
            .inv_evt   (inv_evt[i]),
            .invalid   (invalid[i])
        );
    end

    assign any_evt = |inv_evt;

    // Registered alongside the per-cell flags: equals the OR of their next
    // values, so it never lags the flags by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            invalid_any <= 1'b0;
        end else begin
            invalid_any <= any_evt | ((|invalid) & ~bus.err_clr);
        end
    end

    // One step per event cycle regardless of how many channels fired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_cnt <= '0;
        end else if (any_evt) begin
            if (bus.err_clr) begin
                inv_cnt <= CNT_W'(1);
            end else if (inv_cnt != CNT_MAX) begin
                inv_cnt <= inv_cnt + CNT_W'(1);
            end
        end else if (bus.err_clr) begin
            inv_cnt <= '0;
        end
    end

    assign bus.q           = q;
    assign bus.q_n         = ~q;
    assign bus.invalid     = invalid;
    assign bus.invalid_any = invalid_any;
    assign bus.inv_cnt     = inv_cnt;

endmodule

// File: tb/tb_gated_sr_bank.sv
// Directed self-checking bench for gated_sr_bank.
// Four WIDTH=8 banks (one per MODE) and one CNT_W=3 bank share the same
// stimulus; all use RESET_VAL=8'hA5.
module tb_gated_sr_bank;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] ch_en;
    logic [7:0] s;
    logic [7:0] r;
    logic       clr;
    logic       err_clr;

    int n_checks;
    int n_errors;

    logic [7:0] mq   [4];
    logic [7:0] mqn  [4];
    logic [7:0] minv [4];
    logic       many [4];
    logic [7:0] mcnt [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        gated_sr_bank_if #(.WIDTH(8), .CNT_W(8)) bus ();
        assign bus.en      = en;
        assign bus.ch_en   = ch_en;
        assign bus.s       = s;
        assign bus.r       = r;
        assign bus.clr     = clr;
        assign bus.err_clr = err_clr;
        gated_sr_bank #(
            .WIDTH(8), .MODE(g), .RESET_VAL(8'hA5), .CNT_W(8)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
        assign mq[g]   = bus.q;
        assign mqn[g]  = bus.q_n;
        assign minv[g] = bus.invalid;
        assign many[g] = bus.invalid_any;
        assign mcnt[g] = bus.inv_cnt;
    end

    gated_sr_bank_if #(.WIDTH(8), .CNT_W(3)) bus_sat ();
    assign bus_sat.en      = en;
    assign bus_sat.ch_en   = ch_en;
    assign bus_sat.s       = s;
    assign bus_sat.r       = r;
    assign bus_sat.clr     = clr;
    assign bus_sat.err_clr = err_clr;

    gated_sr_bank #(
        .WIDTH(8), .MODE(0), .RESET_VAL(8'hA5), .CNT_W(3)
    ) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_sat)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [7:0] ce, input logic [7:0] sv,
                         input logic [7:0] rv, input logic c, input logic ec);
        en = e; ch_en = ce; s = sv; r = rv; clr = c; err_clr = ec;
    endtask

    logic [7:0] exp_m1 [4];
    logic [7:0] exp_m2 [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_m1 = '{8'h00, 8'h01, 8'h00, 8'h01};
        exp_m2 = '{8'h00, 8'h01, 8'h00, 8'h00};

        // 1: reset values
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_q",       mq[0],          8'hA5);
        check("rst_qn",      mqn[0],         8'h5A);
        check("rst_inv",     minv[0],        8'h00);
        check("rst_any",     many[0],        1'b0);
        check("rst_cnt",     mcnt[0],        8'h00);
        check("rst_sat_cnt", bus_sat.inv_cnt, 3'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_hold", mq[0], 8'hA5);

        // 2: enables
        drive(1'b1, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0);
        tick();
        check("en_q",  mq[0],  8'h0F);
        check("en_qn", mqn[0], 8'hF0);
        drive(1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
        tick();
        check("gen_off", mq[0], 8'h0F);
        drive(1'b1, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0);
        tick();
        check("ch01", mq[0], 8'h0F);
        drive(1'b1, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0);
        tick();
        check("ch80",     mq[0],   8'h8F);
        check("no_inv_2", minv[0], 8'h00);

        // 3: MODE sweep from q=00
        drive(1'b1, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
        tick();
        check("sweep_start", mq[3], 8'h00);
        drive(1'b1, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0);
        tick();
        for (int m = 0; m < 4; m++) check($sformatf("m%0d_e1", m), mq[m], exp_m1[m]);
        tick();
        for (int m = 0; m < 4; m++) begin
            check($sformatf("m%0d_e2", m),  mq[m],   exp_m2[m]);
            check($sformatf("m%0d_inv", m), minv[m], 8'h01);
            check($sformatf("m%0d_any", m), many[m], 1'b1);
            check($sformatf("m%0d_cnt", m), mcnt[m], 8'd2);
        end

        // 4: multi-channel event counts once; err_clr vs new event
        drive(1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
        tick();
        check("eclr_inv", minv[0], 8'h00);
        check("eclr_any", many[0], 1'b0);
        check("eclr_cnt", mcnt[0], 8'd0);
        check("eclr_q",   mq[0],   8'h00);
        drive(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
        tick();
        check("ff_cnt", mcnt[0], 8'd1);
        check("ff_inv", minv[0], 8'hFF);
        drive(1'b1, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b1);
        tick();
        check("race_inv", minv[0], 8'h01);
        check("race_cnt", mcnt[0], 8'd1);
        check("race_any", many[0], 1'b1);

        // mid-stream asynchronous reset, no edge in between
        rst_n = 1'b0;
        #2;
        check("async_q",   mq[0],   8'hA5);
        check("async_inv", minv[0], 8'h00);
        check("async_any", many[0], 1'b0);
        check("async_cnt", mcnt[0], 8'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0);
        tick();
        check("first_edge_q", mq[0], 8'h0F);

        // 5: saturation on CNT_W=3
        drive(1'b1, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0);
        repeat (7) tick();
        check("sat_7", bus_sat.inv_cnt, 3'd7);
        repeat (3) tick();
        check("sat_hold",  bus_sat.inv_cnt, 3'd7);
        check("cnt8_10",   mcnt[0],         8'd10);

        // 6: clr
        drive(1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);
        tick();
        check("clr_q",   mq[0],   8'hA5);
        check("clr_inv", minv[0], 8'h00);
        drive(1'b1, 8'hFF, 8'h04, 8'h04, 1'b1, 1'b0);
        tick();
        check("clr_sr_q",   mq[0],   8'hA5);
        check("clr_sr_inv", minv[0], 8'h04);
        check("clr_sr_cnt", mcnt[0], 8'd1);
        drive(1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
        tick();
        check("eclr_keeps_q", mq[0],   8'hA5);
        check("eclr_inv2",    minv[0], 8'h00);

        // disabled channel / global disable with S=R=1: no event
        drive(1'b1, 8'hFE, 8'h01, 8'h01, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
        tick();
        check("dis_inv", minv[0], 8'h00);
        check("dis_cnt", mcnt[0], 8'd0);
        check("dis_q",   mq[0],   8'hA5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
